// File: rtl/alu_ctrl_flagpipe.sv
// alu_ctrl_flagpipe: pipelined ALU control decoder owning the carry/zero flags,
// with a per-flag pending scoreboard that stalls conditional ops behind older writers.
module alu_ctrl_flagpipe #(
  parameter int OPW          = 4,
  parameter int FNW          = 2,
  parameter int CTLW         = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  alu_op,
  input  logic [FNW-1:0]  func,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [CTLW-1:0] alu_ctrl,
  output logic            out_wr_c,
  output logic            out_wr_z,
  input  logic            flag_wb_c,
  input  logic            c_val,
  input  logic            flag_wb_z,
  input  logic            z_val,
  input  logic            flush,
  output logic            carry_q,
  output logic            zero_q,
  output logic            err_underflow
);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  logic [CW-1:0]   pend_c, pend_z;
  logic [1:0]      f;
  logic [CTLW-1:0] ctl;
  logic legal, is_add, is_adc, is_adz, is_ndu, is_ndc, is_ndz;
  logic may_wc, may_wz, hazard, accept, do_add, do_nand, wc, wz, inc_c, inc_z;
  assign f      = func[1:0];
  assign legal  = (func >> 2) == '0;
  assign is_add = legal & ((alu_op == OPW'(0)) | (alu_op == OPW'(1) & (f == 2'd0 | f == 2'd3)));
  assign is_adc = legal & alu_op == OPW'(1) & f == 2'd2;
  assign is_adz = legal & alu_op == OPW'(1) & f == 2'd1;
  assign is_ndu = legal & alu_op == OPW'(2) & f == 2'd0;
  assign is_ndc = legal & alu_op == OPW'(2) & f == 2'd2;
  assign is_ndz = legal & alu_op == OPW'(2) & f == 2'd1;
  // Conditionals count as potential writers so a full counter can never overflow.
  assign may_wc = is_add | is_adc | is_adz;
  assign may_wz = may_wc | is_ndu | is_ndc | is_ndz;
  assign hazard = ((is_adc | is_ndc) & pend_c != '0) | ((is_adz | is_ndz) & pend_z != '0) |
                  (may_wc & pend_c == CW'(MAX_INFLIGHT)) | (may_wz & pend_z == CW'(MAX_INFLIGHT));
  assign in_ready = (!out_valid | out_ready) & !hazard & !flush;
  assign accept   = in_valid & in_ready;
  assign do_add   = is_add | (is_adc & carry_q) | (is_adz & zero_q);
  assign do_nand  = is_ndu | (is_ndc & carry_q) | (is_ndz & zero_q);
  assign ctl      = do_add ? CTLW'(0) : do_nand ? CTLW'(1) : CTLW'(2);
  assign wc       = do_add;
  assign wz       = do_add | do_nand;
  assign inc_c    = accept & wc;
  assign inc_z    = accept & wz;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid     <= 1'b0;
      alu_ctrl      <= CTLW'(2);
      out_wr_c      <= 1'b0;
      out_wr_z      <= 1'b0;
      carry_q       <= 1'b0;
      zero_q        <= 1'b0;
      pend_c        <= '0;
      pend_z        <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (flag_wb_c) carry_q <= c_val;
      if (flag_wb_z) zero_q <= z_val;
      if (flush) begin
        out_valid <= 1'b0;
        pend_c    <= '0;
        pend_z    <= '0;
      end else begin
        if (accept) begin
          out_valid <= 1'b1;
          alu_ctrl  <= ctl;
          out_wr_c  <= wc;
          out_wr_z  <= wz;
        end else if (out_ready) out_valid <= 1'b0;
        if (inc_c & !flag_wb_c) pend_c <= pend_c + CW'(1);
        else if (!inc_c & flag_wb_c) begin
          if (pend_c == '0) err_underflow <= 1'b1;
          else pend_c <= pend_c - CW'(1);
        end
        if (inc_z & !flag_wb_z) pend_z <= pend_z + CW'(1);
        else if (!inc_z & flag_wb_z) begin
          if (pend_z == '0) err_underflow <= 1'b1;
          else pend_z <= pend_z - CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_ctrl_flagpipe.sv
// tb_alu_ctrl_flagpipe: directed vectors; expected issue results go into a queue
// and a negedge monitor pops/compares them on every output handshake.
module tb_alu_ctrl_flagpipe;
  logic clk = 0, reset_n = 0, in_valid = 0, in_ready, out_ready = 1, out_valid;
  logic [3:0] alu_op = 0;
  logic [1:0] func = 0, alu_ctrl;
  logic out_wr_c, out_wr_z, flag_wb_c = 0, c_val = 0, flag_wb_z = 0, z_val = 0, flush = 0;
  logic carry_q, zero_q, err_underflow;
  logic [3:0] sbq[$];
  int pass = 0, total = 0;

  alu_ctrl_flagpipe dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .func(func), .out_ready(out_ready), .out_valid(out_valid),
    .alu_ctrl(alu_ctrl), .out_wr_c(out_wr_c), .out_wr_z(out_wr_z),
    .flag_wb_c(flag_wb_c), .c_val(c_val), .flag_wb_z(flag_wb_z), .z_val(z_val),
    .flush(flush), .carry_q(carry_q), .zero_q(zero_q), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      total++;
      if (sbq.size() == 0) $display("FAIL out_unexpected: got ctl=%0d wc=%0b wz=%0b, required no output", alu_ctrl, out_wr_c, out_wr_z);
      else begin
        logic [3:0] e;
        e = sbq.pop_front();
        if ({alu_ctrl, out_wr_c, out_wr_z} == e) pass++;
        else $display("FAIL out_mismatch: got ctl=%0d wc=%0b wz=%0b, required ctl=%0d wc=%0b wz=%0b",
                      alu_ctrl, out_wr_c, out_wr_z, e[3:2], e[1], e[0]);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0d, required %0d", nm, act, exp);
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] fn, input logic [1:0] ec,
                       input logic ewc, input logic ewz, input bit push);
    in_valid = 1; alu_op = op; func = fn;
    for (int n = 0; ; n++) begin
      #2;
      if (in_ready) break;
      if (n == 30) begin
        total++;
        $display("FAIL issue_timeout: got in_ready=0 for op=%0d func=%0d, required 1", op, fn);
        in_valid = 0;
        return;
      end
      @(posedge clk); #1;
    end
    if (push) sbq.push_back({ec, ewc, ewz});
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wb(input logic c, input logic cv, input logic z, input logic zv);
    flag_wb_c = c; c_val = cv; flag_wb_z = z; z_val = zv;
    @(posedge clk); #1;
    flag_wb_c = 0; flag_wb_z = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_ctrl", alu_ctrl, 2);
    chk("rst_wr", {out_wr_c, out_wr_z}, 0);
    chk("rst_flags", {carry_q, zero_q}, 0);
    chk("rst_err", err_underflow, 0);
    reset_n = 1;
    @(posedge clk); #1;
    // plain ADD, then ADC with carry=0 resolves to NOP
    issue(4'b0001, 2'b00, 2'd0, 1, 1, 1);
    wb(1, 0, 1, 0);
    chk("carry_after_wb0", carry_q, 0);
    issue(4'b0001, 2'b10, 2'd2, 0, 0, 1);
    issue(4'b0001, 2'b00, 2'd0, 1, 1, 1);
    wb(1, 1, 1, 1);
    chk("carry_after_wb1", carry_q, 1);
    issue(4'b0001, 2'b10, 2'd0, 1, 1, 1);
    wb(1, 0, 1, 1);
    chk("err_clean", err_underflow, 0);
    // ADD then NDZ stalls until zero writeback; resolves with the new zero=0
    issue(4'b0001, 2'b00, 2'd0, 1, 1, 1);
    in_valid = 1; alu_op = 4'b0010; func = 2'b01;
    #2 chk("ndz_stall0", in_ready, 0);
    @(posedge clk); #1;
    #2 chk("ndz_stall1", in_ready, 0);
    @(posedge clk); #1;
    flag_wb_z = 1; z_val = 0; flag_wb_c = 1; c_val = 1;
    #2 chk("ndz_stall_wb_cycle", in_ready, 0);
    @(posedge clk); #1;
    flag_wb_z = 0; flag_wb_c = 0;
    #2 chk("ndz_ready_after_wb", in_ready, 1);
    sbq.push_back({2'd2, 1'b0, 1'b0});
    @(posedge clk); #1;
    in_valid = 0;
    chk("flags_cz", {carry_q, zero_q}, 2'b10);
    // fill pend_z to MAX_INFLIGHT
    for (int i = 0; i < 4; i++) issue(4'b0010, 2'b00, 2'd1, 0, 1, 1);
    in_valid = 1; alu_op = 4'b0010; func = 2'b00;
    #2 chk("ndu_full_stall", in_ready, 0);
    @(posedge clk); #1;
    flag_wb_z = 1; z_val = 1;
    #2 chk("ndu_full_wb_cycle", in_ready, 0);
    @(posedge clk); #1;
    flag_wb_z = 0;
    #2 chk("ndu_after_wb", in_ready, 1);
    sbq.push_back({2'd1, 1'b0, 1'b1});
    @(posedge clk); #1;
    #2 chk("ndu_full_again", in_ready, 0);
    in_valid = 0;
    for (int i = 0; i < 4; i++) wb(0, 0, 1, 1);
    chk("zero_after_drain", zero_q, 1);
    chk("err_after_drain", err_underflow, 0);
    // backpressure: held output stays stable
    out_ready = 0;
    issue(4'b0010, 2'b00, 2'd1, 0, 1, 1);
    in_valid = 1; alu_op = 4'b0010; func = 2'b00;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_hold", {alu_ctrl, out_wr_c, out_wr_z}, 4'b0101);
      @(posedge clk); #1;
    end
    out_ready = 1;
    #2 chk("bp_release_ready", in_ready, 1);
    sbq.push_back({2'd1, 1'b0, 1'b1});
    @(posedge clk); #1;
    in_valid = 0;
    wb(0, 0, 1, 0);
    wb(0, 0, 1, 0);
    // flush with pend_c=2 and a held output
    issue(4'b0001, 2'b00, 2'd0, 1, 1, 1);
    @(posedge clk); #1;
    out_ready = 0;
    issue(4'b0001, 2'b00, 2'd0, 1, 1, 0);
    chk("pre_flush_valid", out_valid, 1);
    flush = 1; flag_wb_z = 1; z_val = 1;
    #2 chk("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 0; flag_wb_z = 0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_zero_upd", zero_q, 1);
    chk("flush_no_err", err_underflow, 0);
    out_ready = 1;
    wb(1, 0, 0, 0);
    chk("underflow_err", err_underflow, 1);
    chk("underflow_carry", carry_q, 0);
    repeat (3) @(posedge clk);
    #1 chk("err_sticky", err_underflow, 1);
    // asynchronous reset in the middle of a stall
    out_ready = 0;
    issue(4'b0010, 2'b00, 2'd1, 0, 1, 0);
    in_valid = 1; alu_op = 4'b0001; func = 2'b00;
    #2 chk("pre_reset_stall", in_ready, 0);
    reset_n = 0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_alu_ctrl", alu_ctrl, 2);
    chk("arst_err", err_underflow, 0);
    chk("arst_zero", zero_q, 0);
    chk("arst_in_ready", in_ready, 1);
    in_valid = 0;
    @(posedge clk); #1;
    reset_n = 1; out_ready = 1;
    issue(4'b0001, 2'b11, 2'd0, 1, 1, 1);
    issue(4'b0000, 2'b10, 2'd0, 1, 1, 1);
    issue(4'b0011, 2'b00, 2'd2, 0, 0, 1);
    issue(4'b0010, 2'b11, 2'd2, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1 chk("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
